// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side PC sequencer (IDLE/FETCH/ADVANCE/HOLD); optional exception vectoring under `EXC_VECTOR_EN
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  output logic        InstrValid,
  output logic [31:0] PCResult,
  output logic [31:0] PCAddResult
`ifdef EXC_VECTOR_EN
  ,
  input  logic        Exception,
  output logic [31:0] EPC
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, ADVANCE, HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] seq_pc, pc_nx;
  logic upd, take_exc;
  assign PCAddResult = PCResult + 32'd4;
  assign IMemAddr = PCResult;
  assign seq_pc = Jump ? {JumpTarget[31:2], 2'b00} :
                  BranchTaken ? {BranchTarget[31:2], 2'b00} : PCAddResult;
`ifdef EXC_VECTOR_EN
  logic exc_pend;
  assign take_exc = exc_pend && (state == ADVANCE || state == HOLD);
  assign pc_nx = take_exc ? EXC_VECTOR : seq_pc;
  // sticky pending flag; re-armed by an Exception arriving as the vector loads
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      exc_pend <= 1'b0;
      EPC      <= 32'h0;
    end else begin
      exc_pend <= take_exc ? Exception : (exc_pend | Exception);
      if (take_exc) EPC <= PCResult;
    end
  end
`else
  logic unused_exc;
  assign unused_exc = &{1'b0, EXC_VECTOR};
  assign take_exc = 1'b0;
  assign pc_nx = seq_pc;
`endif
  // next-state: redirects are only sampled in ADVANCE/HOLD, so FETCH/IDLE ignore them
  always_comb begin
    state_nx = state;
    upd = 1'b0;
    case (state)
      IDLE:    state_nx = FETCH;
      FETCH:   state_nx = IMemAck ? ADVANCE : FETCH;
      ADVANCE, HOLD: begin
        upd = take_exc || !Stall;
        state_nx = upd ? FETCH : HOLD;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state, PC and registered outputs decoded from the upcoming state
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      PCResult   <= RESET_PC;
      IMemReq    <= 1'b0;
      InstrValid <= 1'b0;
    end else begin
      state      <= state_nx;
      if (upd) PCResult <= pc_nx;
      IMemReq    <= state_nx == FETCH;
      InstrValid <= state_nx == ADVANCE;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic Clk = 1'b0, Reset, Stall, BranchTaken, Jump, IMemAck;
  logic [31:0] BranchTarget, JumpTarget;
  logic IMemReq, InstrValid;
  logic [31:0] IMemAddr, PCResult, PCAddResult;
  int checks = 0, errors = 0;
`ifdef EXC_VECTOR_EN
  logic Exception;
  logic [31:0] EPC;
`endif
  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
    .InstrValid(InstrValid), .PCResult(PCResult), .PCAddResult(PCAddResult)
`ifdef EXC_VECTOR_EN
    , .Exception(Exception), .EPC(EPC)
`endif
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask
  task automatic fetch_state(input string tag, input logic [31:0] pc);
    chk({tag, "_req"}, {31'h0, IMemReq}, 32'd1);
    chk({tag, "_vld"}, {31'h0, InstrValid}, 32'd0);
    chk({tag, "_addr"}, IMemAddr, pc);
  endtask
  task automatic adv_state(input string tag, input logic [31:0] pc);
    chk({tag, "_req"}, {31'h0, IMemReq}, 32'd0);
    chk({tag, "_vld"}, {31'h0, InstrValid}, 32'd1);
    chk({tag, "_pc"}, PCResult, pc);
  endtask
  initial begin
    Reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; IMemAck = 1'b0;
    BranchTarget = 32'h0; JumpTarget = 32'h0;
`ifdef EXC_VECTOR_EN
    Exception = 1'b0;
`endif
    step();
    step();
    chk("rst_req", {31'h0, IMemReq}, 32'd0);
    chk("rst_vld", {31'h0, InstrValid}, 32'd0);
    chk("rst_pc", PCResult, 32'h0);
    chk("rst_pc4", PCAddResult, 32'h4);
    Reset = 1'b1; IMemAck = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      fetch_state("seq_f", 32'(k * 4));
      step();
      adv_state("seq_a", 32'(k * 4));
    end
    Jump = 1'b1; JumpTarget = 32'h10; IMemAck = 1'b0;
    step();
    Jump = 1'b0;
    BranchTaken = 1'b1; BranchTarget = 32'h300;
    for (int i = 0; i < 3; i++) begin
      fetch_state("wait", 32'h10);
      step();
    end
    BranchTaken = 1'b0; IMemAck = 1'b1;
    fetch_state("wait_ack", 32'h10);
    step();
    adv_state("wait_adv", 32'h10);
    step();
    fetch_state("nolatch", 32'h14);
    step();
    adv_state("adv14", 32'h14);
    Jump = 1'b1; JumpTarget = 32'h203; BranchTaken = 1'b1; BranchTarget = 32'h400;
    step();
    fetch_state("jmp_pri", 32'h200);
    Jump = 1'b0; BranchTaken = 1'b0;
    step();
    adv_state("adv200", 32'h200);
    BranchTaken = 1'b1; BranchTarget = 32'h22;
    step();
    fetch_state("br_mask", 32'h20);
    BranchTaken = 1'b0;
    step();
    adv_state("adv20", 32'h20);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_req", {31'h0, IMemReq}, 32'd0);
      chk("hold_vld", {31'h0, InstrValid}, 32'd0);
      chk("hold_pc", PCResult, 32'h20);
    end
    Stall = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h80;
    step();
    fetch_state("hold_br", 32'h80);
    BranchTaken = 1'b0;
    step();
    adv_state("adv80", 32'h80);
    Jump = 1'b1; JumpTarget = 32'hFFFF_FFFF;
    step();
    Jump = 1'b0;
    fetch_state("top", 32'hFFFF_FFFC);
    chk("wrap_pc4", PCAddResult, 32'h0);
    step();
    adv_state("adv_top", 32'hFFFF_FFFC);
    step();
    fetch_state("wrap", 32'h0);
    step();
    step();
    fetch_state("pre_rst", 32'h4);
    Reset = 1'b0;
    step();
    chk("mid_rst_req", {31'h0, IMemReq}, 32'd0);
    chk("mid_rst_vld", {31'h0, InstrValid}, 32'd0);
    chk("mid_rst_pc", PCResult, 32'h0);
    chk("mid_rst_pc4", PCAddResult, 32'h4);
    Reset = 1'b1;
    step();
    fetch_state("post_rst", 32'h0);
`ifdef EXC_VECTOR_EN
    chk("rst_epc", EPC, 32'h0);
    step();
    Jump = 1'b1; JumpTarget = 32'h40;
    step();
    Jump = 1'b0;
    fetch_state("exc_f", 32'h40);
    Exception = 1'b1; Stall = 1'b1;
    step();
    Exception = 1'b0;
    adv_state("exc_a", 32'h40);
    step();
    fetch_state("exc_vec", 32'h80);
    chk("exc_epc", EPC, 32'h40);
    Stall = 1'b0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
